// File: rtl/alu_iterative.sv
// ============================================================================
// Module      : alu_iterative
// Description : Execute-stage ALU. Logic, arithmetic and compare operations
//               complete in one cycle. Shifts run SHIFT_STEP bits per cycle.
//               Valid/ready handshakes on both the input and the output side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iterative #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_SUB   = 4'b0011;
    localparam logic [3:0] c_OP_SLL   = 4'b0100;
    localparam logic [3:0] c_OP_SRL   = 4'b0101;
    localparam logic [3:0] c_OP_XOR   = 4'b0110;
    localparam logic [3:0] c_OP_SRA   = 4'b0111;
    localparam logic [3:0] c_OP_EQ    = 4'b1000;
    localparam logic [3:0] c_OP_PASSB = 4'b1001;
    localparam logic [3:0] c_OP_SLT   = 4'b1100;

    localparam logic [SHAMT_W:0] c_STEP = (SHAMT_W+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_rdy_en;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_shreg;
    logic [SHAMT_W:0]     r_remain;
    logic [WIDTH-1:0]     r_result;
    logic                 r_illegal;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_alu;
    logic                 w_illegal;
    logic                 w_is_shift;
    logic                 w_start_shift;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [SHAMT_W:0]     w_step;
    logic [SHAMT_W:0]     w_remain_nxt;
    logic [WIDTH-1:0]     w_shifted;
    logic signed [WIDTH-1:0] w_sra;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the operands being accepted
    // ------------------------------------------------------------------
    assign w_shamt = SrcB[SHAMT_W-1:0];

    always_comb begin
        w_alu      = '0;
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        case (Operation)
            c_OP_AND:   w_alu = SrcA & SrcB;
            c_OP_OR:    w_alu = SrcA | SrcB;
            c_OP_ADD:   w_alu = SrcA + SrcB;
            c_OP_SUB:   w_alu = SrcA - SrcB;
            c_OP_XOR:   w_alu = SrcA ^ SrcB;
            c_OP_EQ:    w_alu = {{(WIDTH-1){1'b0}}, (SrcA == SrcB)};
            c_OP_PASSB: w_alu = SrcB;
            c_OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            c_OP_SLL, c_OP_SRL, c_OP_SRA: begin
                // a zero shift amount finishes immediately with A unchanged
                w_is_shift = 1'b1;
                w_alu      = SrcA;
            end
            default:    w_illegal = 1'b1;
        endcase
    end

    assign w_start_shift = w_is_shift && (w_shamt != '0);

    // ------------------------------------------------------------------
    // Iterative shifter: at most SHIFT_STEP positions per cycle
    // ------------------------------------------------------------------
    assign w_step       = (r_remain < c_STEP) ? r_remain : c_STEP;
    assign w_remain_nxt = r_remain - w_step;
    // arithmetic shift of the partial result keeps replicating the original sign
    assign w_sra        = $signed(r_shreg) >>> w_step;

    always_comb begin
        w_shifted = r_shreg;
        case (r_op)
            c_OP_SLL: w_shifted = r_shreg << w_step;
            c_OP_SRL: w_shifted = r_shreg >> w_step;
            c_OP_SRA: w_shifted = w_sra;
            default:  w_shifted = r_shreg;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = r_rdy_en;
                if (w_accept) begin
                    w_state_nxt = w_start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_remain_nxt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = r_rdy_en && out_ready;
                if (w_accept) begin
                    w_state_nxt = w_start_shift ? ST_SHIFT : ST_DONE;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_en  <= 1'b0;
            r_op      <= '0;
            r_shreg   <= '0;
            r_remain  <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            // in_ready rises on the first clock edge after reset release
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_op      <= Operation;
                r_illegal <= w_illegal;
                if (w_start_shift) begin
                    r_shreg  <= SrcA;
                    r_remain <= {1'b0, w_shamt};
                end else begin
                    r_result <= w_alu;
                end
            end else if (r_state == ST_SHIFT) begin
                r_shreg  <= w_shifted;
                r_remain <= w_remain_nxt;
                if (w_remain_nxt == '0) begin
                    r_result <= w_shifted;
                end
            end
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign ALUResult = r_result;
    assign Zero      = out_valid && (r_result == '0);
    assign Illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_iterative.sv
// ============================================================================
// Module      : tb_alu_iterative
// Description : Self-checking bench for alu_iterative (vector table, corner
//               sequences, randomized ops against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_iterative;

    localparam int W     = 32;
    localparam int STEP  = 1;
    localparam int STEP4 = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, out_valid, out_ready, Zero, Illegal;
    logic [3:0]    Operation;
    logic [W-1:0]  SrcA, SrcB, ALUResult;

    logic          in4_valid, in4_ready, out4_valid, Zero4, Illegal4;
    logic          out4_ready;
    logic [3:0]    Operation4;
    logic [W-1:0]  SrcA4, SrcB4, ALUResult4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_iterative #(.WIDTH(W), .SHIFT_STEP(STEP)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
    );

    alu_iterative #(.WIDTH(W), .SHIFT_STEP(STEP4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in4_valid), .in_ready(in4_ready),
        .Operation(Operation4), .SrcA(SrcA4), .SrcB(SrcB4),
        .out_valid(out4_valid), .out_ready(out4_ready),
        .ALUResult(ALUResult4), .Zero(Zero4), .Illegal(Illegal4)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         il;
        int           lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: {illegal, result}
    function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned sh;
        logic signed [W-1:0] sa;
        sh = b % W;
        sa = a;
        case (op)
            4'd0:  return {1'b0, a & b};
            4'd1:  return {1'b0, a | b};
            4'd2:  return {1'b0, a + b};
            4'd3:  return {1'b0, a - b};
            4'd4:  return {1'b0, a << sh};
            4'd5:  return {1'b0, a >> sh};
            4'd6:  return {1'b0, a ^ b};
            4'd7:  return {1'b0, W'(sa >>> sh)};
            4'd8:  return {1'b0, W'(a == b)};
            4'd9:  return {1'b0, b};
            4'd12: return {1'b0, W'(sa < $signed(b))};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b, input int step);
        int sh;
        sh = int'(b % W);
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && sh != 0)
            return (sh + step - 1) / step + 1;
        return 1;
    endfunction

    // Issue one op on u_dut and wait for its result; out_ready set by caller.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic z, output logic il, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
        end
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = ALUResult;
        z   = Zero;
        il  = Illegal;
    endtask

    initial begin
        logic [W-1:0] res;
        logic         z, il;
        int           lat, cnt;
        logic [W:0]   m;
        logic [3:0]   legal_ops [11];
        logic [3:0]   bad_ops [5];

        vecs[0]  = '{4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1};
        vecs[1]  = '{4'b0011, 32'd5,         32'd5,         32'd0,         1'b0, 1};
        vecs[2]  = '{4'b0111, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 5};
        vecs[3]  = '{4'b1100, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1};
        vecs[4]  = '{4'b1000, 32'h1234,      32'h1234,      32'd1,         1'b0, 1};
        vecs[5]  = '{4'b1001, 32'd0,         32'hABCD_E000, 32'hABCD_E000, 1'b0, 1};
        vecs[6]  = '{4'b0100, 32'h1234_5678, 32'd32,        32'h1234_5678, 1'b0, 1};
        vecs[7]  = '{4'b1111, 32'h1111_1111, 32'h2222_2222, 32'd0,         1'b1, 1};
        vecs[8]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[9]  = '{4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1};
        vecs[10] = '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1};
        vecs[11] = '{4'b0101, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 32};
        vecs[12] = '{4'b0100, 32'd1,         32'd3,         32'd8,         1'b0, 4};
        vecs[13] = '{4'b1100, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1};
        vecs[14] = '{4'b0011, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1};
        vecs[15] = '{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1};
        vecs[16] = '{4'b1010, 32'd3,         32'd4,         32'd0,         1'b1, 1};

        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};
        bad_ops   = '{4'd10, 4'd11, 4'd13, 4'd14, 4'd15};

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        Operation  = '0;
        SrcA       = '0;
        SrcB       = '0;
        in4_valid  = 1'b0;
        out4_ready = 1'b1;
        Operation4 = '0;
        SrcA4      = '0;
        SrcB4      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), 0);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_result", ALUResult, 0);
        chk("rst_zero", W'(Zero), 0);
        chk("rst_illegal", W'(Illegal), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", W'(in_ready), 1);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, il, lat);
            chk($sformatf("vec%0d_res", i), res, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), W'(z), W'(vecs[i].res == 0));
            chk($sformatf("vec%0d_illegal", i), W'(il), W'(vecs[i].il));
            chk($sformatf("vec%0d_lat", i), W'(lat), W'(vecs[i].lat));
        end

        // SRA by 4, step 1: in_ready low for 4 cycles
        in_valid = 1'b1; Operation = 4'b0111; SrcA = 32'h8000_0000; SrcB = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0; lat = 1;
        while (!out_valid && lat < 100) begin
            if (!in_ready) cnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("sra1_busy_cycles", W'(cnt), 4);
        chk("sra1_lat", W'(lat), 5);

        // Same SRA on the 4-bit-per-cycle instance
        in4_valid = 1'b1; Operation4 = 4'b0111; SrcA4 = 32'h8000_0000; SrcB4 = 32'd4;
        @(posedge clk); #1;
        in4_valid = 1'b0;
        cnt = 0; lat = 1;
        while (!out4_valid && lat < 100) begin
            if (!in4_ready) cnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("sra4_busy_cycles", W'(cnt), 1);
        chk("sra4_lat", W'(lat), 2);
        chk("sra4_res", ALUResult4, 32'hF800_0000);

        // Partial final step: SRL by 7 with step 4
        @(posedge clk); #1;
        in4_valid = 1'b1; Operation4 = 4'b0101; SrcA4 = 32'hFF00_0000; SrcB4 = 32'd7;
        @(posedge clk); #1;
        in4_valid = 1'b0;
        lat = 1;
        while (!out4_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        m = ref_alu(4'b0101, 32'hFF00_0000, 32'd7);
        chk("srl4_lat", W'(lat), W'(ref_lat(4'b0101, 32'd7, STEP4)));
        chk("srl4_res", ALUResult4, m[W-1:0]);

        // Output stall: result held, new requests ignored
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd3; SrcB = 32'd4;
        @(posedge clk); #1;
        Operation = 4'b0011; SrcA = 32'd9; SrcB = 32'd1;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", W'(out_valid), 1);
            chk("stall_res", ALUResult, 32'd7);
            chk("stall_in_ready", W'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            Operation = 4'b0010; SrcA = W'(k); SrcB = W'(10 * k);
            @(posedge clk); #1;
            chk("b2b_valid", W'(out_valid), 1);
            chk($sformatf("b2b_res%0d", k), ALUResult, W'(11 * k));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain_valid", W'(out_valid), 0);

        // Reset in the middle of a long shift
        in_valid = 1'b1; Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", W'(out_valid), 0);
        chk("midrst_res", ALUResult, 0);
        chk("midrst_in_ready", W'(in_ready), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_ready", W'(in_ready), 1);
        run_op(4'b0010, 32'd1, 32'd1, res, z, il, lat);
        chk("midrst_add_res", res, 32'd2);
        chk("midrst_add_lat", W'(lat), 1);

        // Randomized ops against the reference model
        for (int r = 0; r < 200; r++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
            else                           op = legal_ops[$urandom_range(0, 10)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            m = ref_alu(op, a, b);
            run_op(op, a, b, res, z, il, lat);
            chk($sformatf("rnd%0d_op%0d_res", r, op), res, m[W-1:0]);
            chk($sformatf("rnd%0d_zero", r), W'(z), W'(m[W-1:0] == 0));
            chk($sformatf("rnd%0d_illegal", r), W'(il), W'(m[W]));
            chk($sformatf("rnd%0d_lat", r), W'(lat), W'(ref_lat(op, b, STEP)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
